calc_engine: RTL and testbench

Sequential datapath that consumes the four mutually exclusive button-command lines (enter, number, total, clear) and the error line from the button-decode controller. It builds decimal operands digit by digit, accumulates them, and presents a running total. It is the receiving end of the controller's command interface and sits between the controller and the display driver.

---
 rtl/calc_engine_if.sv | 39 +++
 rtl/calc_engine.sv | 165 ++++++++++++++++
 tb/tb_calc_engine.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_engine_if.sv
// calc_engine_if: command/result bundle between the button-decode controller
// (master) and the calc_engine datapath (slave).
//
// Signalling: enter/number/total/clear/err_in are levels held by the
// controller; the engine edge-detects the four command lines itself, so a
// command is taken once per rising edge of its line and there is no ready
// back-pressure. digit is sampled in the cycle the number edge is seen.
// result_valid is a one-cycle pulse qualifying result; the consumer must
// take it that cycle (no ready). state is a debug view of the engine FSM.
interface calc_engine_if #(
  parameter int WIDTH = 16
);
  logic             enter;
  logic             number;
  logic             total;
  logic             clear;
  logic             err_in;
  logic [3:0]       digit;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             error;
  logic             overflow;
  logic [2:0]       digit_count;
  logic [1:0]       state;

  modport master (
    output enter, number, total, clear, err_in, digit,
    input  operand, acc, result, result_valid, error, overflow,
           digit_count, state
  );

  modport slave (
    input  enter, number, total, clear, err_in, digit,
    output operand, acc, result, result_valid, error, overflow,
           digit_count, state
  );
endinterface

// File: rtl/calc_engine.sv
// calc_engine: builds decimal operands digit by digit, accumulates them and
// presents a running total. Commands arrive as levels and are edge-detected.
// Optional build macro CALC_SATURATE_EN: overflow clamps to 2^WIDTH-1 and
// continues instead of entering ERROR.
module calc_engine #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input logic          clk,
  input logic          rst,
  calc_engine_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENTRY  = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

`ifdef CALC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH+3:0] MAX_EXT = {4'b0000, {WIDTH{1'b1}}};
  localparam logic [WIDTH+3:0] TEN     = (WIDTH+4)'(10);
  localparam logic [2:0]       MAX_CNT = 3'(MAX_DIGITS);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rv_q, rv_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       cnt_q, cnt_d;
  // prev copies of {clear, total, enter, number}
  logic [3:0]       prev_q;

  logic [3:0]       lines;
  logic [3:0]       fire;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] sum_val;
  logic [WIDTH-1:0] base;
  logic [2:0]       base_cnt;
  logic [WIDTH+3:0] prod;
  logic             prod_ovf;

  assign lines = {bus.clear, bus.total, bus.enter, bus.number};
  assign fire  = lines & ~prev_q;

  // Arithmetic shared by enter/total and number paths.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, operand_q};
    sum_ovf  = sum[WIDTH];
    sum_val  = sum_ovf ? MAX_VAL : sum[WIDTH-1:0];
    // A new digit after a total starts a fresh operand; acc chains on.
    base     = (state_q == S_RESULT) ? '0 : operand_q;
    base_cnt = (state_q == S_RESULT) ? 3'd0 : cnt_q;
    prod     = {4'b0000, base} * TEN + {{WIDTH{1'b0}}, bus.digit};
    prod_ovf = (prod > MAX_EXT);
  end

  // Next-state: err_in first, then clear > total > enter > number.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    result_d  = result_q;
    rv_d      = 1'b0;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;

    if (bus.err_in) begin
      state_d = S_ERROR;
    end else if (fire[3]) begin
      state_d   = S_IDLE;
      operand_d = '0;
      acc_d     = '0;
      result_d  = '0;
      ovf_d     = 1'b0;
      cnt_d     = 3'd0;
    end else if (state_q == S_ERROR) begin
      state_d = S_ERROR;
    end else if (fire[2]) begin
      if (state_q == S_ENTRY && sum_ovf && !SAT) begin
        ovf_d   = 1'b1;
        state_d = S_ERROR;
      end else begin
        if (state_q == S_ENTRY) begin
          acc_d    = sum_val;
          result_d = sum_val;
          ovf_d    = ovf_q | sum_ovf;
        end else begin
          result_d = acc_q;
        end
        rv_d      = 1'b1;
        operand_d = '0;
        cnt_d     = 3'd0;
        state_d   = S_RESULT;
      end
    end else if (fire[1]) begin
      if (state_q == S_ENTRY) begin
        if (sum_ovf && !SAT) begin
          ovf_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          acc_d     = sum_val;
          ovf_d     = ovf_q | sum_ovf;
          operand_d = '0;
          cnt_d     = 3'd0;
          state_d   = S_IDLE;
        end
      end
    end else if (fire[0]) begin
      if (bus.digit > 4'd9) begin
        state_d = S_ERROR;
      end else if (base_cnt == MAX_CNT) begin
        state_d = state_q;
      end else if (prod_ovf && !SAT) begin
        ovf_d   = 1'b1;
        state_d = S_ERROR;
      end else begin
        operand_d = prod_ovf ? MAX_VAL : prod[WIDTH-1:0];
        ovf_d     = ovf_q | prod_ovf;
        cnt_d     = base_cnt + 3'd1;
        state_d   = S_ENTRY;
      end
    end
  end

  // State and datapath registers; prev copies reset high to mask held lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= 3'd0;
      prev_q    <= 4'b1111;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      prev_q    <= lines;
    end
  end

  assign bus.operand      = operand_q;
  assign bus.acc          = acc_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.error        = (state_q == S_ERROR);
  assign bus.overflow     = ovf_q;
  assign bus.digit_count  = cnt_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: directed bench for calc_engine with hand-computed values.
module tb_calc_engine;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENTRY  = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] exp_q[$];

  calc_engine_if #(.WIDTH(16)) bus ();

  calc_engine #(.WIDTH(16), .MAX_DIGITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_num(input logic [3:0] d);
    bus.digit  = d;
    bus.number = 1'b1;
    tick();
    bus.number = 1'b0;
    tick();
  endtask

  task automatic press_enter();
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick();
  endtask

  task automatic press_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
  endtask

  // Checkers
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Presses total and checks the pulse against the scoreboard queue.
  task automatic press_total_expect(input string tag);
    logic [15:0] e;
    e = exp_q.pop_front();
    bus.total = 1'b1;
    tick();
    check({tag, "_rv"}, {31'd0, bus.result_valid}, 32'd1);
    check({tag, "_result"}, {16'd0, bus.result}, {16'd0, e});
    bus.total = 1'b0;
    tick();
    check({tag, "_rv_drop"}, {31'd0, bus.result_valid}, 32'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.enter  = 1'b0;
    bus.number = 1'b0;
    bus.total  = 1'b0;
    bus.clear  = 1'b0;
    bus.err_in = 1'b0;
    bus.digit  = 4'd0;
    repeat (2) tick();

    // Reset state
    check("rst_state", {30'd0, bus.state}, S_IDLE);
    check("rst_operand", {16'd0, bus.operand}, 32'd0);
    check("rst_acc", {16'd0, bus.acc}, 32'd0);
    check("rst_result", {16'd0, bus.result}, 32'd0);
    check("rst_flags", {29'd0, bus.result_valid, bus.error, bus.overflow}, 32'd0);
    check("rst_count", {29'd0, bus.digit_count}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic sum 12 + 30 = 42
    press_num(4'd1);
    check("sum_d1_state", {30'd0, bus.state}, S_ENTRY);
    press_num(4'd2);
    check("sum_op12", {16'd0, bus.operand}, 32'd12);
    check("sum_cnt2", {29'd0, bus.digit_count}, 32'd2);
    press_enter();
    check("sum_acc12", {16'd0, bus.acc}, 32'd12);
    check("sum_op_clr", {16'd0, bus.operand}, 32'd0);
    check("sum_idle", {30'd0, bus.state}, S_IDLE);
    press_num(4'd3);
    press_num(4'd0);
    check("sum_op30", {16'd0, bus.operand}, 32'd30);
    press_enter();
    exp_q.push_back(16'd42);
    press_total_expect("sum_total");
    check("sum_acc42", {16'd0, bus.acc}, 32'd42);
    check("sum_result_state", {30'd0, bus.state}, S_RESULT);
    // Repeated total re-pulses the same value
    exp_q.push_back(16'd42);
    press_total_expect("sum_retotal");

    // Chaining: new operand after RESULT, total does implicit enter
    press_num(4'd5);
    check("chain_op5", {16'd0, bus.operand}, 32'd5);
    check("chain_acc42", {16'd0, bus.acc}, 32'd42);
    exp_q.push_back(16'd47);
    press_total_expect("chain_total");
    check("chain_acc47", {16'd0, bus.acc}, 32'd47);

    // Held button: one edge only
    bus.digit  = 4'd7;
    bus.number = 1'b1;
    repeat (5) tick();
    bus.number = 1'b0;
    tick();
    check("held_op7", {16'd0, bus.operand}, 32'd7);
    check("held_cnt1", {29'd0, bus.digit_count}, 32'd1);
    press_num(4'd3);
    check("held_op73", {16'd0, bus.operand}, 32'd73);

    // Bad digit
    press_num(4'd10);
    check("bad_error", {31'd0, bus.error}, 32'd1);
    check("bad_op_hold", {16'd0, bus.operand}, 32'd73);
    bus.total = 1'b1;
    tick();
    check("bad_total_rv", {31'd0, bus.result_valid}, 32'd0);
    check("bad_total_result", {16'd0, bus.result}, 32'd47);
    bus.total = 1'b0;
    tick();
    press_clear();
    check("bad_clr_error", {31'd0, bus.error}, 32'd0);
    check("bad_clr_acc", {16'd0, bus.acc}, 32'd0);
    check("bad_clr_state", {30'd0, bus.state}, S_IDLE);

    // Max digits and accumulator overflow
    press_num(4'd6);
    press_num(4'd5);
    press_num(4'd5);
    press_num(4'd3);
    press_num(4'd5);
    press_num(4'd1);
    check("max_op", {16'd0, bus.operand}, 32'd65535);
    check("max_cnt", {29'd0, bus.digit_count}, 32'd5);
    press_enter();
    check("max_acc", {16'd0, bus.acc}, 32'd65535);
    press_num(4'd1);
    press_enter();
    check("aovf_flag", {31'd0, bus.overflow}, 32'd1);
    check("aovf_acc", {16'd0, bus.acc}, 32'd65535);
`ifdef CALC_SATURATE_EN
    check("aovf_error", {31'd0, bus.error}, 32'd0);
    check("aovf_state", {30'd0, bus.state}, S_IDLE);
`else
    check("aovf_error", {31'd0, bus.error}, 32'd1);
    check("aovf_op_hold", {16'd0, bus.operand}, 32'd1);
`endif
    press_clear();
    check("aovf_clr_ovf", {31'd0, bus.overflow}, 32'd0);

    // Operand overflow: 6553 * 10 + 6 = 65536
    press_num(4'd6);
    press_num(4'd5);
    press_num(4'd5);
    press_num(4'd3);
    press_num(4'd6);
    check("oovf_flag", {31'd0, bus.overflow}, 32'd1);
`ifdef CALC_SATURATE_EN
    check("oovf_op", {16'd0, bus.operand}, 32'd65535);
    check("oovf_state", {30'd0, bus.state}, S_ENTRY);
`else
    check("oovf_op", {16'd0, bus.operand}, 32'd6553);
    check("oovf_state", {30'd0, bus.state}, S_ERROR);
`endif
    press_clear();

    // err_in during ENTRY
    press_num(4'd1);
    press_num(4'd2);
    bus.err_in = 1'b1;
    tick();
    bus.err_in = 1'b0;
    check("err_error", {31'd0, bus.error}, 32'd1);
    check("err_op12", {16'd0, bus.operand}, 32'd12);
    press_enter();
    check("err_enter_acc", {16'd0, bus.acc}, 32'd0);
    check("err_enter_op", {16'd0, bus.operand}, 32'd12);
    bus.err_in = 1'b1;
    bus.clear  = 1'b1;
    tick();
    check("err_clear_lose", {30'd0, bus.state}, S_ERROR);
    bus.err_in = 1'b0;
    bus.clear  = 1'b0;
    tick();
    press_clear();
    check("err_clr_op", {16'd0, bus.operand}, 32'd0);
    check("err_clr_state", {30'd0, bus.state}, S_IDLE);
    check("err_clr_flags", {30'd0, bus.error, bus.overflow}, 32'd0);

    // Reset mid-operation with number held
    press_num(4'd4);
    bus.digit  = 4'd5;
    bus.number = 1'b1;
    tick();
    check("rmid_op45", {16'd0, bus.operand}, 32'd45);
    #2 rst = 1'b1;
    #1;
    check("rmid_async_op", {16'd0, bus.operand}, 32'd0);
    check("rmid_async_cnt", {29'd0, bus.digit_count}, 32'd0);
    #2 rst = 1'b0;
    repeat (2) tick();
    check("rmid_held_op", {16'd0, bus.operand}, 32'd0);
    bus.number = 1'b0;
    tick();
    press_num(4'd9);
    check("rmid_op9", {16'd0, bus.operand}, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
